// File: rtl/pipeline_sched_if.sv
// Handshake/control bundle between the pipeline datapath and pipeline_sched.
//   master : the datapath side. It drives the run/step/halt requests and the hazard
//            and branch inputs, and receives the enables, flushes and counters.
//   slave  : the scheduler side, with the opposite directions.
// Signals:
//   run, step, halt_req, halt_instr            sequencer requests
//   id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt  load-use hazard inputs
//   pc_src                                     branch taken (resolved in MEM)
//   pc_enable, if_id_enable, pipe_enable       stage enables
//   id_ex_bubble, flush_if_id/id_ex/ex_m       latch clear controls
//   state, cycle_count, stall_count            status and counters
interface pipeline_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             step;
  logic             halt_req;
  logic             halt_instr;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             pc_src;
  logic             pc_enable;
  logic             if_id_enable;
  logic             pipe_enable;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_m;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output run, step, halt_req, halt_instr, id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
           pc_src,
    input  pc_enable, if_id_enable, pipe_enable, id_ex_bubble, flush_if_id, flush_id_ex,
           flush_ex_m, state, cycle_count, stall_count
  );

  modport slave (
    input  run, step, halt_req, halt_instr, id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
           pc_src,
    output pc_enable, if_id_enable, pipe_enable, id_ex_bubble, flush_if_id, flush_id_ex,
           flush_ex_m, state, cycle_count, stall_count
  );
endinterface

// File: rtl/pipeline_sched.sv
// Run/step/halt sequencer and hazard controller for the 5-stage pipeline.
// It drives the PC, IF/ID and back-end enables, inserts load-use bubbles, flushes on
// taken branches, drains the back end before halting, and counts cycles and stalls.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  pipeline_sched_if.slave (requests, hazard/branch inputs, enables, flushes,
//        state and counters)
// The enable, flush and bubble outputs are combinational from the current state and
// inputs. The state and the counters update on the next edge.
module pipeline_sched #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_sched_if.slave  bus
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DrainLoad = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } state_e;

  state_e           state_q;
  logic [DW-1:0]    drain_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;

  logic hz;
  logic halt_any;
  logic adv;
  logic pc_en, if_id_en, pipe_en, bubble, fl_if_id, fl_id_ex, fl_ex_m;

  always_comb begin
    hz = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
         ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));
    halt_any = bus.halt_req | bus.halt_instr;
    adv = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);
  end

  always_comb begin
    pc_en    = 1'b0;
    if_id_en = 1'b0;
    pipe_en  = 1'b0;
    bubble   = 1'b0;
    fl_if_id = 1'b0;
    fl_id_ex = 1'b0;
    fl_ex_m  = 1'b0;
    case (state_q)
      StRun, StStep: begin
        pipe_en = 1'b1;
        if (bus.pc_src) begin
          // A taken branch squashes the younger instructions, so any hazard among them
          // is irrelevant. The PC loads the branch target.
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          fl_if_id = 1'b1;
          fl_id_ex = 1'b1;
          fl_ex_m  = 1'b1;
        end else if (hz) begin
          // Hold PC and IF/ID, and send a NOP into EX for one cycle.
          bubble = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
      StDrain: begin
        // Fetch is frozen and NOPs enter at IF/ID while the back end drains.
        pipe_en  = 1'b1;
        fl_if_id = 1'b1;
        fl_id_ex = bus.pc_src;
        fl_ex_m  = bus.pc_src;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      drain_q <= '0;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (adv && (cycle_q != '1)) cycle_q <= cycle_q + CNT_W'(1);
      if (bubble && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      case (state_q)
        StIdle: begin
          if (bus.run) begin
            state_q <= StRun;
          end else if (bus.step) begin
            state_q <= StStep;
          end else if (bus.halt_req) begin
            state_q <= StDrain;
            drain_q <= DrainLoad;
          end
        end
        StRun: begin
          if (halt_any) begin
            state_q <= StDrain;
            drain_q <= DrainLoad;
          end else if (!bus.run) begin
            state_q <= StIdle;
          end
        end
        StStep: begin
          if (halt_any) begin
            state_q <= StDrain;
            drain_q <= DrainLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (drain_q == '0) state_q <= StHalted;
          else drain_q <= drain_q - DW'(1);
        end
        StHalted: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pc_enable    = pc_en;
  assign bus.if_id_enable = if_id_en;
  assign bus.pipe_enable  = pipe_en;
  assign bus.id_ex_bubble = bubble;
  assign bus.flush_if_id  = fl_if_id;
  assign bus.flush_id_ex  = fl_id_ex;
  assign bus.flush_ex_m   = fl_ex_m;
  assign bus.state        = state_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.stall_count  = stall_q;

endmodule
